alu_seq: RTL and testbench

//  Parametrised, registered successor to the 4-function combinational lab ALU.
//  - Adds a Start/Busy/Done handshake, a multi-cycle shift-add multiply, and a wrapping accumulator.
//  - Keeps the original four operations.
//  - Sits between operand registers (switches/bus) and the result display or bus.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/mul_shift_add.sv | 63 ++++++
 rtl/alu_seq.sv | 98 +++++++++
 tb/tb_alu_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential lab ALU: operation codes and FSM states.
package alu_pkg;

    // Operation select carried on the Function port
    typedef enum logic [2:0] {
        ADD  = 3'd0,
        ORR  = 3'd1,
        ANDR = 3'd2,
        CAT  = 3'd3,
        MUL  = 3'd4,
        ACC  = 3'd5,
        RSV6 = 3'd6,
        RSV7 = 3'd7
    } func_t;

    // Control FSM states (prefixed so they do not collide with func_t labels)
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Bit counter width able to hold 0..n-1, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add multiplier datapath: one multiplier bit consumed per step.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             load,
    input  logic             step,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic [2*N-1:0]   product,
    output logic             last
);

    localparam int unsigned W  = 2 * N;
    localparam int unsigned CW = cnt_width(N);

    logic [W-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  addend;

    // Next-state: load captures operands, step adds the shifted multiplicand when the current bit is set
    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        product  = acc_q + addend;
        last     = (cnt_q == CW'(N - 1));
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = W'(A);
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = product;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // Operand, partial-product and counter registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered lab ALU with Start/Busy/Done handshake, multi-cycle multiply and accumulator.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [2:0]       Function,
    output logic [2*N-1:0]   ALUOut,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned W = 2 * N;

    state_t       state_q;
    logic [W-1:0] alu_out_q;
    logic         busy_q;
    logic         done_q;

    func_t        func;
    logic [W-1:0] single_res;
    logic         mul_load;
    logic         mul_step;
    logic [W-1:0] mul_product;
    logic         mul_last;

    assign func     = func_t'(Function);
    assign mul_load = (state_q == ST_IDLE) && Start && (func == MUL);
    assign mul_step = (state_q == ST_MUL);

    // Single-cycle result; MUL and reserved codes yield zero here
    always_comb begin
        single_res = '0;
        case (func)
            ADD:     single_res = W'(A) + W'(B);
            ORR:     single_res = W'(|A | |B);
            ANDR:    single_res = W'(&A & &B);
            CAT:     single_res = W'({A, B});
            ACC:     single_res = alu_out_q + W'(A);
            default: single_res = '0;
        endcase
    end

    mul_shift_add #(.N(N)) u_mul (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .load    (mul_load),
        .step    (mul_step),
        .A       (A),
        .B       (B),
        .product (mul_product),
        .last    (mul_last)
    );

    // Control FSM with registered result, Busy and Done
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            alu_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        if (func == MUL) begin
                            busy_q  <= 1'b1;
                            state_q <= ST_MUL;
                        end else begin
                            alu_out_q <= single_res;
                            done_q    <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        alu_out_q <= mul_product;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ALUOut = alu_out_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at N=4 and N=8.
module tb_alu_seq;

    logic       Clock;
    logic       Resetn;

    logic       start4;
    logic [3:0] a4, b4;
    logic [2:0] fn4;
    logic [7:0] out4;
    logic       busy4, done4;

    logic       start8;
    logic [7:0] a8, b8;
    logic [2:0] fn8;
    logic [15:0] out8;
    logic       busy8, done8;

    int checks;
    int failures;

    alu_seq #(.N(4)) dut4 (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (start4),
        .A        (a4),
        .B        (b4),
        .Function (fn4),
        .ALUOut   (out4),
        .Busy     (busy4),
        .Done     (done4)
    );

    alu_seq #(.N(8)) dut8 (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (start8),
        .A        (a8),
        .B        (b8),
        .Function (fn8),
        .ALUOut   (out8),
        .Busy     (busy8),
        .Done     (done8)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs driven here
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Resetn = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; fn4 = 3'd0;
        start8 = 1'b0; a8 = '0; b8 = '0; fn8 = 3'd0;
        tick();
        tick();
        check("rst_out", {8'h0, out4}, 16'h0000);
        check("rst_busy", {15'h0, busy4}, 16'h0);
        check("rst_done", {15'h0, done4}, 16'h0);
        Resetn = 1'b1;
        tick();

        // 1: ADD F+F
        start4 = 1'b1; fn4 = 3'd0; a4 = 4'hF; b4 = 4'hF;
        tick();
        start4 = 1'b0;
        check("add_out", {8'h0, out4}, 16'h001E);
        check("add_done", {15'h0, done4}, 16'h1);
        check("add_busy", {15'h0, busy4}, 16'h0);
        tick();
        check("add_done_drop", {15'h0, done4}, 16'h0);
        check("add_hold", {8'h0, out4}, 16'h001E);

        // 2: MUL F*F, operands disturbed while busy
        start4 = 1'b1; fn4 = 3'd4; a4 = 4'hF; b4 = 4'hF;
        tick();
        start4 = 1'b0; a4 = 4'h2; b4 = 4'h3; fn4 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            check("mul_busy", {15'h0, busy4}, 16'h1);
            check("mul_out_held", {8'h0, out4}, 16'h001E);
            check("mul_no_done", {15'h0, done4}, 16'h0);
            tick();
        end
        check("mul_busy_last", {15'h0, busy4}, 16'h1);
        tick();
        check("mul_ff", {8'h0, out4}, 16'h00E1);
        check("mul_ff_done", {15'h0, done4}, 16'h1);
        check("mul_ff_busy", {15'h0, busy4}, 16'h0);
        tick();
        check("mul_ff_done_drop", {15'h0, done4}, 16'h0);

        // 2b: MUL 0*9
        start4 = 1'b1; fn4 = 3'd4; a4 = 4'h0; b4 = 4'h9;
        tick();
        start4 = 1'b0;
        tick(); tick(); tick();
        check("mul_09_pending", {8'h0, out4}, 16'h00E1);
        tick();
        check("mul_09", {8'h0, out4}, 16'h0000);
        check("mul_09_done", {15'h0, done4}, 16'h1);
        tick();

        // 3: ADD Start held through busy window, including the final MUL edge
        start4 = 1'b1; fn4 = 3'd4; a4 = 4'hF; b4 = 4'hF;
        tick();
        fn4 = 3'd0; a4 = 4'h1; b4 = 4'h1;
        for (int i = 0; i < 3; i++) begin
            check("ign_no_done", {15'h0, done4}, 16'h0);
            check("ign_out_held", {8'h0, out4}, 16'h0000);
            tick();
        end
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ign_mul", {8'h0, out4}, 16'h00E1);
        check("ign_done", {15'h0, done4}, 16'h1);
        tick();
        check("ign_single_done", {15'h0, done4}, 16'h0);
        check("ign_out_final", {8'h0, out4}, 16'h00E1);

        // 4: CAT then ACC wrap, then held ACC
        start4 = 1'b1; fn4 = 3'd3; a4 = 4'hF; b4 = 4'hE;
        tick();
        check("cat", {8'h0, out4}, 16'h00FE);
        fn4 = 3'd5; a4 = 4'h3;
        tick();
        check("acc_wrap", {8'h0, out4}, 16'h0001);
        tick();
        check("acc_1", {8'h0, out4}, 16'h0004);
        check("acc_1_done", {15'h0, done4}, 16'h1);
        tick();
        check("acc_2", {8'h0, out4}, 16'h0007);
        check("acc_2_done", {15'h0, done4}, 16'h1);
        tick();
        start4 = 1'b0;
        check("acc_3", {8'h0, out4}, 16'h000A);
        check("acc_3_done", {15'h0, done4}, 16'h1);
        tick();
        check("acc_idle_done", {15'h0, done4}, 16'h0);
        check("acc_idle_hold", {8'h0, out4}, 16'h000A);

        // 5: reset during MUL cycle 2 aborts it
        start4 = 1'b1; fn4 = 3'd4; a4 = 4'hF; b4 = 4'hF;
        tick();
        start4 = 1'b0;
        tick();
        Resetn = 1'b0;
        #1;
        check("abort_out", {8'h0, out4}, 16'h0000);
        check("abort_busy", {15'h0, busy4}, 16'h0);
        tick();
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", {15'h0, done4}, 16'h0);
            tick();
        end
        start4 = 1'b1; fn4 = 3'd4; a4 = 4'h3; b4 = 4'h5;
        tick();
        start4 = 1'b0;
        tick(); tick(); tick();
        tick();
        check("mul_35", {8'h0, out4}, 16'h000F);
        check("mul_35_done", {15'h0, done4}, 16'h1);
        tick();

        // 6: reductions and reserved codes
        start4 = 1'b1; fn4 = 3'd1; a4 = 4'h0; b4 = 4'h0;
        tick();
        check("orr_00", {8'h0, out4}, 16'h0000);
        fn4 = 3'd1; a4 = 4'h0; b4 = 4'h4;
        tick();
        check("orr_04", {8'h0, out4}, 16'h0001);
        fn4 = 3'd2; a4 = 4'hF; b4 = 4'hE;
        tick();
        check("andr_fe", {8'h0, out4}, 16'h0000);
        fn4 = 3'd2; a4 = 4'hF; b4 = 4'hF;
        tick();
        check("andr_ff", {8'h0, out4}, 16'h0001);
        fn4 = 3'd7;
        tick();
        check("rsv7", {8'h0, out4}, 16'h0000);
        fn4 = 3'd3; a4 = 4'hA; b4 = 4'h5;
        tick();
        check("cat_a5", {8'h0, out4}, 16'h00A5);
        fn4 = 3'd6;
        tick();
        start4 = 1'b0;
        check("rsv6", {8'h0, out4}, 16'h0000);
        check("rsv6_done", {15'h0, done4}, 16'h1);
        check("rsv6_busy", {15'h0, busy4}, 16'h0);
        tick();

        // N=8 regression: FF*FF in 8 cycles
        start8 = 1'b1; fn8 = 3'd4; a8 = 8'hFF; b8 = 8'hFF;
        tick();
        start8 = 1'b0; a8 = 8'h00;
        for (int i = 0; i < 7; i++) begin
            check("mul8_busy", {15'h0, busy8}, 16'h1);
            check("mul8_held", out8, 16'h0000);
            tick();
        end
        tick();
        check("mul8_ff", out8, 16'hFE01);
        check("mul8_done", {15'h0, done8}, 16'h1);
        check("mul8_busy_drop", {15'h0, busy8}, 16'h0);
        tick();
        check("mul8_done_drop", {15'h0, done8}, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
